// File: rtl/loeffler_row_ctrl.sv
// rtl/loeffler_row_ctrl.sv - row sequencer for the loeffler_1d 1-D DCT datapath
// Fetches an 8x8 block row by row from a sync sample RAM and tags each coefficient.
module loeffler_row_ctrl #(
    parameter int ROWS     = 8,
    parameter int COMP_CYC = 8,
    parameter int CLR_CYC  = 10,
    parameter int AW       = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rdata,
    output logic [7:0]    dct_in,
    output logic [1:0]    dct_state,
    output logic          dct_rstn,
    input  logic [11:0]   dct_out,
    output logic          coef_valid,
    output logic [11:0]   coef_data,
    output logic [2:0]    coef_row,
    output logic [2:0]    coef_idx
);

    localparam int CNT_MAX = (COMP_CYC > CLR_CYC) ? COMP_CYC : CLR_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_FEED, S_LATCH, S_COMPUTE, S_CLEAR, S_DONE
    } state_t;

    state_t        state;
    logic [2:0]    row;
    logic [CW-1:0] cnt;
    logic          feed;

    // RAM data arrives one cycle after the read, so the feed phase passes it straight through
    assign dct_in = feed ? mem_rdata : 8'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            row        <= 3'd0;
            cnt        <= '0;
            feed       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            mem_rd     <= 1'b0;
            mem_addr   <= '0;
            dct_state  <= 2'd3;
            dct_rstn   <= 1'b0;
            coef_valid <= 1'b0;
            coef_data  <= 12'd0;
            coef_row   <= 3'd0;
            coef_idx   <= 3'd0;
        end else begin
            done       <= 1'b0;
            coef_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_FETCH;
                        row       <= 3'd0;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        mem_rd    <= 1'b1;
                        mem_addr  <= '0;
                        dct_state <= 2'd0;
                        dct_rstn  <= 1'b1;
                    end
                end
                S_FETCH: begin
                    state    <= S_FEED;
                    feed     <= 1'b1;
                    cnt      <= '0;
                    mem_addr <= mem_addr + AW'(1);
                end
                S_FEED: begin
                    if (cnt == CW'(7)) begin
                        state     <= S_LATCH;
                        feed      <= 1'b0;
                        dct_state <= 2'd1;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                        // the read for the last sample was issued one cycle earlier
                        if (cnt == CW'(6))
                            mem_rd <= 1'b0;
                        else
                            mem_addr <= mem_addr + AW'(1);
                    end
                end
                S_LATCH: begin
                    state     <= S_COMPUTE;
                    dct_state <= 2'd2;
                    cnt       <= '0;
                end
                S_COMPUTE: begin
                    if (cnt < CW'(8)) begin
                        coef_valid <= 1'b1;
                        coef_data  <= dct_out;
                        coef_row   <= row;
                        coef_idx   <= cnt[2:0];
                    end
                    if (cnt == CW'(COMP_CYC - 1)) begin
                        state     <= S_CLEAR;
                        dct_state <= 2'd3;
                        dct_rstn  <= 1'b0;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_CLEAR: begin
                    if (cnt == CW'(CLR_CYC - 1)) begin
                        cnt <= '0;
                        if (row == 3'(ROWS - 1)) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            // address sits on the last sample of this row, so +1 is the next row base
                            state     <= S_FETCH;
                            row       <= row + 3'd1;
                            mem_rd    <= 1'b1;
                            mem_addr  <= mem_addr + AW'(1);
                            dct_state <= 2'd0;
                            dct_rstn  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_loeffler_row_ctrl.sv
// tb/tb_loeffler_row_ctrl.sv - directed self-checking bench for loeffler_row_ctrl
module tb_loeffler_row_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        start_s = 1'b0;
    logic [11:0] dct_out = 12'd0;
    logic [7:0]  mem [64];

    logic        busy, done, mem_rd, dct_rstn, coef_valid;
    logic [5:0]  mem_addr;
    logic [7:0]  mem_rdata = 8'd0;
    logic [7:0]  dct_in;
    logic [1:0]  dct_state;
    logic [11:0] coef_data;
    logic [2:0]  coef_row, coef_idx;

    logic        busy_s, done_s, mem_rd_s, dct_rstn_s, coef_valid_s;
    logic [5:0]  mem_addr_s;
    logic [7:0]  mem_rdata_s = 8'd0;
    logic [7:0]  dct_in_s;
    logic [1:0]  dct_state_s;
    logic [11:0] coef_data_s;
    logic [2:0]  coef_row_s, coef_idx_s;

    int npass, nfail, nchk;
    int unsigned dcnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];
    always @(posedge clk) if (mem_rd_s) mem_rdata_s <= mem[mem_addr_s];

    always @(negedge clk) begin
        dcnt++;
        dct_out = 12'((dcnt * 37 + 11) % 4096);
    end

    loeffler_row_ctrl u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .dct_in(dct_in), .dct_state(dct_state), .dct_rstn(dct_rstn), .dct_out(dct_out),
        .coef_valid(coef_valid), .coef_data(coef_data), .coef_row(coef_row), .coef_idx(coef_idx)
    );

    loeffler_row_ctrl #(.ROWS(2), .COMP_CYC(10), .CLR_CYC(1), .AW(6)) u_swp (
        .clk(clk), .rst(rst), .start(start_s), .busy(busy_s), .done(done_s),
        .mem_rd(mem_rd_s), .mem_addr(mem_addr_s), .mem_rdata(mem_rdata_s),
        .dct_in(dct_in_s), .dct_state(dct_state_s), .dct_rstn(dct_rstn_s), .dct_out(dct_out),
        .coef_valid(coef_valid_s), .coef_data(coef_data_s), .coef_row(coef_row_s), .coef_idx(coef_idx_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int r, p, e_busy, e_done, e_state, e_rstn, e_rd, e_in, e_cv;
        int ncoef, ndone, nbusy;
        npass = 0; nfail = 0; nchk = 0;
        for (int i = 0; i < 64; i++) mem[i] = 8'(i);

        // reset values
        tick(); tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_mem_rd", 32'(mem_rd), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_dct_in", 32'(dct_in), 0);
        check("rst_dct_state", 32'(dct_state), 3);
        check("rst_dct_rstn", 32'(dct_rstn), 0);
        check("rst_coef_valid", 32'(coef_valid), 0);
        check("rst_coef_data", 32'(coef_data), 0);
        check("rst_coef_row", 32'(coef_row), 0);
        check("rst_coef_idx", 32'(coef_idx), 0);
        @(negedge clk) rst = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 0);

        // single block with start pulses during busy and during DONE
        ncoef = 0;
        start = 1'b1;
        for (int n = 1; n <= 228; n++) begin
            tick();
            start = (n == 50 || n == 225);
            r = 0; p = 0;
            if (n <= 224) begin
                r = (n - 1) / 28;
                p = (n - 1) % 28;
                e_busy = 1; e_done = 0;
                e_state = (p < 9) ? 0 : (p == 9) ? 1 : (p < 18) ? 2 : 3;
                e_rstn = (p < 18) ? 1 : 0;
                e_rd = (p < 8) ? 1 : 0;
                e_in = (p >= 1 && p <= 8) ? r * 8 + p - 1 : 0;
                e_cv = (p >= 11 && p <= 18) ? 1 : 0;
            end else begin
                e_busy = 0; e_done = (n == 225) ? 1 : 0;
                e_state = 3; e_rstn = 0; e_rd = 0; e_in = 0; e_cv = 0;
            end
            check("busy", 32'(busy), e_busy);
            check("done", 32'(done), e_done);
            check("dct_state", 32'(dct_state), e_state);
            check("dct_rstn", 32'(dct_rstn), e_rstn);
            check("mem_rd", 32'(mem_rd), e_rd);
            if (e_rd == 1) check("mem_addr", 32'(mem_addr), r * 8 + p);
            check("dct_in", 32'(dct_in), e_in);
            check("coef_valid", 32'(coef_valid), e_cv);
            if (coef_valid) ncoef++;
            if (e_cv == 1) begin
                check("coef_row", 32'(coef_row), r);
                check("coef_idx", 32'(coef_idx), p - 11);
                check("coef_data", 32'(coef_data), 32'(dct_out));
            end
        end
        check("coef_count", ncoef, 64);

        // start held high: second block FETCH right after the IDLE cycle
        ndone = 0;
        start = 1'b1;
        for (int n = 1; n <= 315; n++) begin
            tick();
            if (done) ndone++;
            if (n == 225) check("held_done", 32'(done), 1);
            if (n == 226) begin
                check("held_idle_busy", 32'(busy), 0);
                check("held_idle_rd", 32'(mem_rd), 0);
            end
            if (n == 227) begin
                check("held_fetch_busy", 32'(busy), 1);
                check("held_fetch_rd", 32'(mem_rd), 1);
                check("held_fetch_addr", 32'(mem_addr), 0);
                check("held_fetch_state", 32'(dct_state), 0);
            end
        end
        check("held_ndone", ndone, 1);
        check("row3_feed_in", 32'(dct_in), 27);
        check("row3_feed_addr", 32'(mem_addr), 28);
        check("row3_feed_rd", 32'(mem_rd), 1);

        // asynchronous reset in the middle of row 3 feed
        start = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_state", 32'(dct_state), 3);
        check("mid_rst_rstn", 32'(dct_rstn), 0);
        check("mid_rst_rd", 32'(mem_rd), 0);
        check("mid_rst_cv", 32'(coef_valid), 0);
        check("mid_rst_in", 32'(dct_in), 0);
        @(negedge clk) rst = 1'b0;
        ndone = 0; nbusy = 0;
        for (int n = 0; n < 300; n++) begin
            tick();
            if (done) ndone++;
            if (busy) nbusy++;
        end
        check("post_rst_done", ndone, 0);
        check("post_rst_busy", nbusy, 0);

        // parameter sweep ROWS=2 COMP_CYC=10 CLR_CYC=1
        ndone = 0;
        start_s = 1'b1;
        for (int n = 1; n <= 45; n++) begin
            tick();
            start_s = 1'b0;
            if (done_s) ndone++;
            if (n <= 42) begin
                r = (n - 1) / 21;
                p = (n - 1) % 21;
                e_busy = 1; e_done = 0;
                e_state = (p < 9) ? 0 : (p == 9) ? 1 : (p < 20) ? 2 : 3;
                e_cv = (p >= 11 && p <= 18) ? 1 : 0;
            end else begin
                r = 0; p = 0;
                e_busy = 0; e_done = (n == 43) ? 1 : 0;
                e_state = 3; e_cv = 0;
            end
            check("swp_busy", 32'(busy_s), e_busy);
            check("swp_done", 32'(done_s), e_done);
            check("swp_dct_state", 32'(dct_state_s), e_state);
            check("swp_coef_valid", 32'(coef_valid_s), e_cv);
            if (e_cv == 1) begin
                check("swp_coef_row", 32'(coef_row_s), r);
                check("swp_coef_idx", 32'(coef_idx_s), p - 11);
            end
        end
        check("swp_ndone", ndone, 1);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/loeffler_row_ctrl.md
Name: loeffler_row_ctrl

Overview:
- Row sequencer for the loeffler_1d 1-D DCT datapath; generates its 2-bit phase code, its active-low datapath reset and its serial 8-bit sample stream.
- Fetches an 8x8 block (64 samples) row by row from a synchronous sample RAM and tags each returned coefficient with its row/index for the downstream transpose buffer.
- One start/done job per block.

Parameters:
- ROWS, 8, rows per block (row length fixed at 8 samples).
- COMP_CYC, 8, cycles spent in the compute phase (dct_state=2), one coefficient per cycle; must be >= 8.
- CLR_CYC, 10, cycles the datapath is held cleared between rows (dct_state=3, dct_rstn=0); min 1.
- AW, 6, sample RAM address width (ROWS*8 <= 2**AW).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- start  in  1  begin a block; sampled in IDLE only
- busy  out  1  high from FETCH through last CLEAR cycle
- done  out  1  one-cycle pulse after the last row completes
- mem_rd  out  1  sample RAM read enable
- mem_addr  out  AW  sample RAM address
- mem_rdata  in  8  RAM read data, valid the cycle after mem_rd
- dct_in  out  8  sample to loeffler_1d
- dct_state  out  2  phase code to loeffler_1d: 0 feed, 1 latch, 2 compute, 3 clear
- dct_rstn  out  1  datapath reset, active-low
- dct_out  in  12  coefficient from loeffler_1d
- coef_valid  out  1  coef_data/coef_row/coef_idx valid
- coef_data  out  12  registered copy of dct_out
- coef_row  out  3  row index of coef_data
- coef_idx  out  3  coefficient index 0..7

Behaviour:
- Reset, async on rst=1: FSM=IDLE; busy=0, done=0, mem_rd=0, mem_addr=0, dct_in=0, dct_state=3, dct_rstn=0, coef_valid=0, coef_data=0, coef_row=0, coef_idx=0; row/sample/phase counters=0.
- States: IDLE, FETCH, FEED, LATCH, COMPUTE, CLEAR, DONE.
- IDLE: dct_state=3, dct_rstn=0. start=1 at a clock edge -> FETCH; row counter=0.
- FETCH (1 cycle):
  - mem_rd=1, mem_addr=row*8.
  - dct_state=0, dct_rstn=1, dct_in=0.
- FEED (8 cycles, k=0..7):
  - dct_state=0, dct_in=mem_rdata (sample row*8+k).
  - For k<7: mem_rd=1, mem_addr=row*8+k+1. For k=7: mem_rd=0.
  - After k=7 -> LATCH.
- LATCH (1 cycle): dct_state=1, dct_in=0.
- COMPUTE (COMP_CYC cycles, c=0..COMP_CYC-1):
  - dct_state=2.
  - For c<8: coef_data<=dct_out, coef_valid<=1, coef_row<=row, coef_idx<=c (registered, appear 1 cycle later).
  - coef_valid is 0 for c>=8.
- CLEAR (CLR_CYC cycles): dct_state=3, dct_rstn=0.
  - Exit: if row==ROWS-1 -> DONE, else row+1 -> FETCH.
- DONE (1 cycle): done=1, busy=0 -> IDLE.
- Outputs in non-feed states: dct_in=0; mem_rd=0 outside FETCH/FEED.
- Latency per row: 10+COMP_CYC+CLR_CYC cycles (28 at defaults).
  - Start edge to done pulse: ROWS*28+1 = 225 cycles.
  - busy high for exactly 224 cycles.
- start while busy or DONE: ignored, no queuing.
- start held high continuously: new block begins the cycle after DONE returns to IDLE.
- coef_valid last pulse (row ROWS-1, idx 7) may coincide with the first CLEAR cycle; still delivered.
- Address wrap: mem_addr never exceeds ROWS*8-1; no wrap.
- rst mid-block: immediate return to reset values; no done pulse; partial coefficients discarded by consumer.

Test Plan:
- Reset: rst=1 mid-FEED of row 3 -> next sample: busy=0, dct_state=3, dct_rstn=0, mem_rd=0, coef_valid=0; no done afterwards.
- Single block, RAM preloaded with value = address (0..63), loeffler_1d model:
  - dct_in sequence 0..7 in row 0, 56..63 in row 7.
  - mem_addr leads dct_in by exactly 1 cycle.
  - done exactly 225 cycles after start edge.
- Phase trace for row 0 at defaults: dct_state = 0 x9, 1 x1, 2 x8, 3 x10; dct_rstn low only in the 10 clear cycles.
- Coefficient tagging: 64 coef_valid pulses total, coef_row 0..7 each with coef_idx 0..7 in order; coef_data equals dct_out one cycle earlier.
- start asserted during busy and during DONE -> ignored; start held high -> second block FETCH in cycle after the IDLE cycle, addresses restart at 0.
- Parameter sweep COMP_CYC=10, CLR_CYC=1, ROWS=2:
  - Per-row latency 21, done at cycle 43.
  - coef_valid low for compute cycles 8 and 9.
